// File: rtl/hcsr04_medidor.sv
// HC-SR04 ranging: trigger pulse, echo timing, BCD distance in cm with rounding/saturation at 999.
// Latency: pronto 2 cycles after echo_s fall is seen; no backpressure, the result is held until the next ARMAZENA.
module hcsr04_medidor #(
    parameter int TRIGGER_CYCLES = 500,
    parameter int CYCLES_PER_CM  = 2941,
    parameter int TIMEOUT_CYCLES = 1_500_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam int TRIG_W = (TRIGGER_CYCLES > 1) ? $clog2(TRIGGER_CYCLES) : 1;
    localparam int TICK_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [TRIG_W-1:0] TRIG_MAX = TRIG_W'(TRIGGER_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CYCLES_PER_CM - 1);
    localparam logic [TICK_W-1:0] TICK_MEIO = TICK_W'(CYCLES_PER_CM / 2);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PREPARA       = 4'd1,
        ENVIA_TRIGGER = 4'd2,
        ESPERA_ECHO   = 4'd3,
        MEDINDO       = 4'd4,
        ARMAZENA      = 4'd5,
        FINAL         = 4'd6,
        ERRO          = 4'd7
    } estado_t;

    estado_t            r_estado;
    estado_t            w_proximo;
    logic               r_echo_m;
    logic               r_echo_s;
    logic [TRIG_W-1:0]  r_trig_cnt;
    logic [TICK_W-1:0]  r_tick;
    logic [TO_W-1:0]    r_timeout;
    logic [11:0]        r_bcd;
    logic [11:0]        r_medida;
    logic               w_trig_fim;
    logic               w_tick_fim;
    logic               w_timeout;

    // Three-digit BCD increment that sticks at 999 instead of wrapping.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] c;
        logic [3:0] d;
        logic [3:0] u;
        {c, d, u} = v;
        if (v == 12'h999) begin
            return v;
        end
        if (u != 4'd9) begin
            u = u + 4'd1;
        end else begin
            u = 4'd0;
            if (d != 4'd9) begin
                d = d + 4'd1;
            end else begin
                d = 4'd0;
                c = c + 4'd1;
            end
        end
        return {c, d, u};
    endfunction

    assign w_trig_fim = (r_trig_cnt == TRIG_MAX);
    assign w_tick_fim = (r_tick == TICK_MAX);
    assign w_timeout  = (r_timeout == TO_MAX);
    assign medida     = r_medida;
    assign db_estado  = r_estado;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo = r_estado;
        trigger   = 1'b0;
        pronto    = 1'b0;
        erro      = 1'b0;
        case (r_estado)
            INICIAL:       if (medir) w_proximo = PREPARA;
            PREPARA:       w_proximo = ENVIA_TRIGGER;
            ENVIA_TRIGGER: begin
                trigger = 1'b1;
                if (w_trig_fim) w_proximo = ESPERA_ECHO;
            end
            ESPERA_ECHO: begin
                if (r_echo_s)       w_proximo = MEDINDO;
                else if (w_timeout) w_proximo = ERRO;
            end
            MEDINDO: begin
                if (!r_echo_s)      w_proximo = ARMAZENA;
                else if (w_timeout) w_proximo = ERRO;
            end
            ARMAZENA:      w_proximo = FINAL;
            FINAL: begin
                pronto    = 1'b1;
                w_proximo = INICIAL;
            end
            ERRO: begin
                erro      = 1'b1;
                w_proximo = INICIAL;
            end
            default:       w_proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_echo_m   <= 1'b0;
            r_echo_s   <= 1'b0;
            r_trig_cnt <= '0;
            r_tick     <= '0;
            r_timeout  <= '0;
            r_bcd      <= 12'h000;
            r_medida   <= 12'h000;
        end else begin
            r_echo_m <= echo;
            r_echo_s <= r_echo_m;
            case (r_estado)
                PREPARA: begin
                    r_trig_cnt <= '0;
                    r_tick     <= '0;
                    r_timeout  <= '0;
                    r_bcd      <= 12'h000;
                end
                ENVIA_TRIGGER: r_trig_cnt <= r_trig_cnt + 1'b1;
                ESPERA_ECHO:   r_timeout <= r_echo_s ? '0 : r_timeout + 1'b1;
                // The cycle that sees echo_s fall is still a tick of the pulse width.
                MEDINDO: begin
                    r_timeout <= r_timeout + 1'b1;
                    if (w_tick_fim) begin
                        r_tick <= '0;
                        r_bcd  <= bcd_inc(r_bcd);
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ARMAZENA: r_medida <= (r_tick >= TICK_MEIO) ? bcd_inc(r_bcd) : r_bcd;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hcsr04_medidor.sv
// Randomized self-checking bench for hcsr04_medidor against an arithmetic distance model.
module tb_hcsr04_medidor;

    localparam int TRIG = 10;
    localparam int CPC  = 20;
    localparam int TMO  = 30000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        medir = 1'b0;
    logic        echo  = 1'b0;
    logic        trigger;
    logic [11:0] medida;
    logic        pronto;
    logic        erro;
    logic [3:0]  db_estado;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pronto = 0;
    int n_erro   = 0;
    int n_trig   = 0;
    int n_both   = 0;

    hcsr04_medidor #(
        .TRIGGER_CYCLES(TRIG),
        .CYCLES_PER_CM (CPC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .medir    (medir),
        .echo     (echo),
        .trigger  (trigger),
        .medida   (medida),
        .pronto   (pronto),
        .erro     (erro),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (pronto) n_pronto++;
        if (erro) n_erro++;
        if (trigger) n_trig++;
        if (pronto && erro) n_both++;
    end

    // Echo width in clocks -> rounded centimetres, capped at 999, as BCD.
    function automatic logic [11:0] modelo(input int w);
        int cm;
        cm = w / CPC;
        if ((w % CPC) >= (CPC / 2)) cm++;
        if (cm > 999) cm = 999;
        return {4'(cm / 100), 4'((cm / 10) % 10), 4'(cm % 10)};
    endfunction

    task automatic tick_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic medir_pulso;
        @(negedge clock);
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
    endtask

    // Returns at the first negedge with trigger low after it was high (FSM in ESPERA_ECHO).
    task automatic esperar_trigger_fim(output bit ok);
        int  k;
        bit  viu;
        k = 0;
        viu = 1'b0;
        while (k < 200 && !trigger) begin @(negedge clock); k++; end
        viu = trigger;
        while (k < 200 && trigger) begin @(negedge clock); k++; end
        ok = viu && !trigger;
    endtask

    task automatic pulso_echo(input int w, input bit medir_meio);
        echo = 1'b1;
        if (medir_meio) begin
            tick_n(w / 2);
            medir = 1'b1;
            @(negedge clock);
            medir = 1'b0;
            tick_n(w - w / 2 - 1);
        end else begin
            tick_n(w);
        end
        echo = 1'b0;
    endtask

    task automatic esperar_fim(output bit ok);
        int k;
        k = 0;
        while (k < 300 && !(pronto || erro)) begin @(negedge clock); k++; end
        ok = pronto || erro;
        tick_n(5);
    endtask

    task automatic medicao(input int w, input int atraso, input bit medir_meio,
                           output logic [11:0] m, output int np, output int ne,
                           output int nt, output bit ok);
        int p0, e0, t0;
        bit ok1, ok2;
        p0 = n_pronto; e0 = n_erro; t0 = n_trig;
        medir_pulso();
        esperar_trigger_fim(ok1);
        tick_n(atraso);
        pulso_echo(w, medir_meio);
        esperar_fim(ok2);
        m  = medida;
        np = n_pronto - p0;
        ne = n_erro - e0;
        nt = n_trig - t0;
        ok = ok1 && ok2;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick_n(3);
        n_tests++; if (trigger !== 1'b0) begin n_fail++; $display("FAIL reset_trigger got %b exp 0", trigger); end
        n_tests++; if (pronto !== 1'b0) begin n_fail++; $display("FAIL reset_pronto got %b exp 0", pronto); end
        n_tests++; if (erro !== 1'b0) begin n_fail++; $display("FAIL reset_erro got %b exp 0", erro); end
        n_tests++; if (medida !== 12'h000) begin n_fail++; $display("FAIL reset_medida got %h exp 000", medida); end
        n_tests++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL reset_estado got %0d exp 0", db_estado); end
        reset = 1'b1;
        tick_n(2);
    endtask

    task automatic test_nominal;
        int p0, e0, t0, b0;
        bit ok1, ok2;
        p0 = n_pronto; e0 = n_erro; t0 = n_trig; b0 = n_both;
        @(negedge clock);
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
        n_tests++; if (db_estado !== 4'd1 || trigger !== 1'b0) begin n_fail++; $display("FAIL lat_prepara got estado=%0d trig=%b exp 1/0", db_estado, trigger); end
        @(negedge clock);
        n_tests++; if (db_estado !== 4'd2 || trigger !== 1'b1) begin n_fail++; $display("FAIL lat_trigger got estado=%0d trig=%b exp 2/1", db_estado, trigger); end
        esperar_trigger_fim(ok1);
        pulso_echo(CPC * 123, 1'b0);
        esperar_fim(ok2);
        n_tests++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL nominal_timeout got ok=%b%b exp 11", ok1, ok2); end
        n_tests++; if (n_trig - t0 !== TRIG) begin n_fail++; $display("FAIL nominal_trig_len got %0d exp %0d", n_trig - t0, TRIG); end
        n_tests++; if (medida !== 12'h123) begin n_fail++; $display("FAIL nominal_medida got %h exp 123", medida); end
        n_tests++; if (n_pronto - p0 !== 1) begin n_fail++; $display("FAIL nominal_pronto got %0d exp 1", n_pronto - p0); end
        n_tests++; if (n_erro - e0 !== 0) begin n_fail++; $display("FAIL nominal_erro got %0d exp 0", n_erro - e0); end
        n_tests++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL nominal_estado got %0d exp 0", db_estado); end
        n_tests++; if (n_both - b0 !== 0) begin n_fail++; $display("FAIL nominal_both got %0d exp 0", n_both - b0); end
    endtask

    task automatic test_rounding;
        logic [11:0] m;
        int np, ne, nt;
        bit ok;
        medicao(CPC * 45 + 9, 3, 1'b0, m, np, ne, nt, ok);
        n_tests++; if (m !== 12'h045 || np !== 1 || !ok) begin n_fail++; $display("FAIL round_down got %h np=%0d exp 045 np=1", m, np); end
        medicao(CPC * 45 + 10, 7, 1'b0, m, np, ne, nt, ok);
        n_tests++; if (m !== 12'h046 || np !== 1 || !ok) begin n_fail++; $display("FAIL round_up got %h np=%0d exp 046 np=1", m, np); end
    endtask

    task automatic test_saturation;
        logic [11:0] m;
        int np, ne, nt;
        bit ok;
        medicao(CPC * 1005, 2, 1'b0, m, np, ne, nt, ok);
        n_tests++; if (m !== 12'h999 || np !== 1 || ne !== 0 || !ok) begin n_fail++; $display("FAIL saturation got %h np=%0d ne=%0d exp 999 1 0", m, np, ne); end
    endtask

    task automatic test_random;
        logic [11:0] m;
        int np, ne, nt, w, d;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            w = $urandom_range(2, 600);
            d = $urandom_range(0, 40);
            medicao(w, d, 1'b0, m, np, ne, nt, ok);
            n_tests++; if (m !== modelo(w) || np !== 1 || ne !== 0 || nt !== TRIG || !ok) begin
                n_fail++; $display("FAIL random w=%0d got %h np=%0d ne=%0d nt=%0d exp %h 1 0 %0d", w, m, np, ne, nt, modelo(w), TRIG);
            end
        end
    endtask

    task automatic test_timeout;
        logic [11:0] prev;
        int p0, e0, c;
        bit ok;
        prev = medida;
        p0 = n_pronto; e0 = n_erro;
        medir_pulso();
        esperar_trigger_fim(ok);
        c = 0;
        while (c < TMO + 1000 && !erro) begin @(negedge clock); c++; end
        n_tests++; if (c !== TMO || !ok) begin n_fail++; $display("FAIL timeout_cycles got %0d exp %0d", c, TMO); end
        tick_n(2);
        n_tests++; if (medida !== prev) begin n_fail++; $display("FAIL timeout_medida got %h exp %h", medida, prev); end
        n_tests++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL timeout_estado got %0d exp 0", db_estado); end
        n_tests++; if (n_erro - e0 !== 1 || n_pronto - p0 !== 0) begin n_fail++; $display("FAIL timeout_pulses got erro=%0d pronto=%0d exp 1 0", n_erro - e0, n_pronto - p0); end
    endtask

    task automatic test_reset_mid;
        logic [11:0] m;
        int np, ne, nt, w;
        bit ok;
        medir_pulso();
        esperar_trigger_fim(ok);
        echo = 1'b1;
        tick_n(300);
        n_tests++; if (db_estado !== 4'd4) begin n_fail++; $display("FAIL midreset_pre got %0d exp 4", db_estado); end
        #2 reset = 1'b0;
        #1;
        n_tests++; if (trigger !== 1'b0 || pronto !== 1'b0 || erro !== 1'b0) begin n_fail++; $display("FAIL midreset_outs got %b%b%b exp 000", trigger, pronto, erro); end
        n_tests++; if (medida !== 12'h000 || db_estado !== 4'd0) begin n_fail++; $display("FAIL midreset_state got %h/%0d exp 000/0", medida, db_estado); end
        @(negedge clock);
        echo = 1'b0;
        tick_n(3);
        reset = 1'b1;
        tick_n(2);
        w = $urandom_range(100, 500);
        medicao(w, 4, 1'b0, m, np, ne, nt, ok);
        n_tests++; if (m !== modelo(w) || np !== 1 || !ok) begin n_fail++; $display("FAIL midreset_after w=%0d got %h np=%0d exp %h 1", w, m, np, modelo(w)); end
    endtask

    task automatic test_ignored_start;
        logic [11:0] m;
        int np, ne, nt;
        bit ok;
        medicao(700, 5, 1'b1, m, np, ne, nt, ok);
        n_tests++; if (m !== modelo(700) || np !== 1 || nt !== TRIG || !ok) begin n_fail++; $display("FAIL ignored got %h np=%0d nt=%0d exp %h 1 %0d", m, np, nt, modelo(700), TRIG); end
        n_tests++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL ignored_estado got %0d exp 0", db_estado); end
    endtask

    task automatic test_back_to_back;
        int w1, w2, k;
        bit ok1, ok2;
        w1 = $urandom_range(50, 300);
        w2 = $urandom_range(50, 300);
        medir = 1'b1;
        esperar_trigger_fim(ok1);
        tick_n(2);
        pulso_echo(w1, 1'b0);
        k = 0;
        while (k < 300 && !pronto) begin @(negedge clock); k++; end
        n_tests++; if (medida !== modelo(w1) || !pronto || !ok1) begin n_fail++; $display("FAIL b2b_first w=%0d got %h exp %h", w1, medida, modelo(w1)); end
        @(negedge clock);
        n_tests++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL b2b_inicial got %0d exp 0", db_estado); end
        @(negedge clock);
        n_tests++; if (db_estado !== 4'd1) begin n_fail++; $display("FAIL b2b_restart got %0d exp 1", db_estado); end
        medir = 1'b0;
        esperar_trigger_fim(ok1);
        pulso_echo(w2, 1'b0);
        esperar_fim(ok2);
        n_tests++; if (medida !== modelo(w2) || !ok1 || !ok2) begin n_fail++; $display("FAIL b2b_second w=%0d got %h exp %h", w2, medida, modelo(w2)); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_rounding();
        test_saturation();
        test_random();
        test_timeout();
        test_reset_mid();
        test_ignored_start();
        test_back_to_back();
        n_tests++; if (n_both !== 0) begin n_fail++; $display("FAIL pronto_erro_overlap got %0d exp 0", n_both); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
